// File: rtl/maze_query_arbiter.sv
// Round-robin arbiter sharing one maze legality checker among NREQ requesters.
// Define MAZE_QUERY_TIMEOUT_EN to give up on a silent checker after TMO cycles.
module maze_query_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 10,
  parameter int TMO  = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*CW-1:0] i_req_x,
  input  logic [NREQ*CW-1:0] i_req_y,
  input  logic [NREQ*2-1:0] i_req_dir,
  output logic              o_mq_valid,
  output logic [CW-1:0]     o_mq_x,
  output logic [CW-1:0]     o_mq_y,
  output logic [1:0]        o_mq_dir,
  input  logic              i_mq_ack,
  input  logic              i_mq_legal,
  output logic [NREQ-1:0]   o_rsp_valid,
  output logic              o_rsp_legal,
  output logic              o_busy
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // The timeout counter is 4 bits wide, so TMO has to fit in it.
  if (TMO < 1 || TMO > 16) begin : g_badTmo
    $error("TMO must be between 1 and 16");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            r_state;
  logic              r_mqValid;
  logic [CW-1:0]     r_mqX;
  logic [CW-1:0]     r_mqY;
  logic [1:0]        r_mqDir;
  logic [GW-1:0]     r_grant;
  logic [GW-1:0]     r_lastGrant;
  logic [NREQ-1:0]   r_rspValid;
  logic              r_rspLegal;
`ifdef MAZE_QUERY_TIMEOUT_EN
  localparam logic [3:0] TMO_LAST = 4'(TMO - 1);
  logic [3:0]        r_tmoCnt;
`endif

  logic [CW-1:0]     w_x   [NREQ];
  logic [CW-1:0]     w_y   [NREQ];
  logic [1:0]        w_dir [NREQ];
  logic              w_found;
  logic [GW-1:0]     w_grantIdx;
  logic [GW-1:0]     w_cand;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_x[g]   = i_req_x[g*CW +: CW];
    assign w_y[g]   = i_req_y[g*CW +: CW];
    assign w_dir[g] = i_req_dir[g*2 +: 2];
  end

  // Search starts one past the last winner so a repeat requester drops to lowest priority.
  always_comb begin
    w_found    = 1'b0;
    w_grantIdx = '0;
    w_cand     = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = GW'((int'(r_lastGrant) + 1 + i) % NREQ);
      if (!w_found && i_req[w_cand]) begin
        w_found    = 1'b1;
        w_grantIdx = w_cand;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_mqValid   <= 1'b0;
      r_mqX       <= '0;
      r_mqY       <= '0;
      r_mqDir     <= '0;
      r_grant     <= '0;
      r_lastGrant <= GW'(NREQ - 1);
      r_rspValid  <= '0;
      r_rspLegal  <= 1'b0;
`ifdef MAZE_QUERY_TIMEOUT_EN
      r_tmoCnt    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant   <= w_grantIdx;
            r_mqX     <= w_x[w_grantIdx];
            r_mqY     <= w_y[w_grantIdx];
            r_mqDir   <= w_dir[w_grantIdx];
            r_mqValid <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_mqValid <= 1'b0;
          r_state   <= WAIT;
`ifdef MAZE_QUERY_TIMEOUT_EN
          r_tmoCnt  <= '0;
`endif
        end
        WAIT: begin
          if (i_mq_ack) begin
            r_rspValid <= NREQ'(1) << r_grant;
            r_rspLegal <= i_mq_legal;
            r_state    <= RESP;
          end
`ifdef MAZE_QUERY_TIMEOUT_EN
          // A checker that never answers is treated as an illegal move.
          else if (r_tmoCnt == TMO_LAST) begin
            r_rspValid <= NREQ'(1) << r_grant;
            r_rspLegal <= 1'b0;
            r_state    <= RESP;
          end else begin
            r_tmoCnt <= r_tmoCnt + 4'd1;
          end
`endif
        end
        RESP: begin
          r_rspValid  <= '0;
          r_rspLegal  <= 1'b0;
          r_lastGrant <= r_grant;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_mq_valid  = r_mqValid;
  assign o_mq_x      = r_mqX;
  assign o_mq_y      = r_mqY;
  assign o_mq_dir    = r_mqDir;
  assign o_rsp_valid = r_rspValid;
  assign o_rsp_legal = r_rspLegal;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_maze_query_arbiter.sv
// Directed bench for maze_query_arbiter: a vector table of full transactions plus
// hand sequences for reset mid-transaction, stray acks and the WAIT timeout.
module tb_maze_query_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 10;
  localparam int TMO  = 15;

  logic              clk = 1'b0;
  logic              rstN;
  logic [NREQ-1:0]   req;
  logic [NREQ*CW-1:0] reqX;
  logic [NREQ*CW-1:0] reqY;
  logic [NREQ*2-1:0] reqDir;
  logic              mqValid;
  logic [CW-1:0]     mqX;
  logic [CW-1:0]     mqY;
  logic [1:0]        mqDir;
  logic              mqAck;
  logic              mqLegal;
  logic [NREQ-1:0]   rspValid;
  logic              rspLegal;
  logic              busy;

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  maze_query_arbiter #(.NREQ(NREQ), .CW(CW), .TMO(TMO)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_req       (req),
    .i_req_x     (reqX),
    .i_req_y     (reqY),
    .i_req_dir   (reqDir),
    .o_mq_valid  (mqValid),
    .o_mq_x      (mqX),
    .o_mq_y      (mqY),
    .o_mq_dir    (mqDir),
    .i_mq_ack    (mqAck),
    .i_mq_legal  (mqLegal),
    .o_rsp_valid (rspValid),
    .o_rsp_legal (rspLegal),
    .o_busy      (busy)
  );

  typedef struct packed {
    logic [3:0]    req;
    logic [CW-1:0] baseX;
    logic [CW-1:0] baseY;
    logic [1:0]    baseDir;
    logic          dropReq;
    logic          legal;
    logic [3:0]    expRsp;
    logic [CW-1:0] expX;
    logic [CW-1:0] expY;
    logic [1:0]    expDir;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Requester i sits at (baseX + 16i, baseY + 16i) heading baseDir ^ i.
  task automatic driveCoords(input logic [CW-1:0] bx, input logic [CW-1:0] by, input logic [1:0] bd);
    for (int i = 0; i < NREQ; i++) begin
      reqX[i*CW +: CW] = bx + CW'(16 * i);
      reqY[i*CW +: CW] = by + CW'(16 * i);
      reqDir[i*2 +: 2] = bd ^ 2'(i);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    driveCoords(v.baseX, v.baseY, v.baseDir);
    req = v.req;
    tick();
    checkOutput({tag, " issue mq_valid"}, 32'(mqValid), 32'd1);
    checkOutput({tag, " issue busy"}, 32'(busy), 32'd1);
    checkOutput({tag, " issue mq_x"}, 32'(mqX), 32'(v.expX));
    checkOutput({tag, " issue mq_y"}, 32'(mqY), 32'(v.expY));
    checkOutput({tag, " issue mq_dir"}, 32'(mqDir), 32'(v.expDir));
    if (v.dropReq) req = '0;
    driveCoords(~v.baseX, ~v.baseY, ~v.baseDir);
    tick();
    checkOutput({tag, " wait mq_valid"}, 32'(mqValid), 32'd0);
    checkOutput({tag, " wait rsp_valid"}, 32'(rspValid), 32'd0);
    mqAck   = 1'b1;
    mqLegal = v.legal;
    tick();
    mqAck   = 1'b0;
    mqLegal = 1'b0;
    req     = '0;
    checkOutput({tag, " resp rsp_valid"}, 32'(rspValid), 32'(v.expRsp));
    checkOutput({tag, " resp rsp_legal"}, 32'(rspLegal), 32'(v.legal));
    checkOutput({tag, " resp mq_x held"}, 32'(mqX), 32'(v.expX));
    checkOutput({tag, " resp mq_dir held"}, 32'(mqDir), 32'(v.expDir));
    tick();
    checkOutput({tag, " idle rsp_valid"}, 32'(rspValid), 32'd0);
    checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic stuckOk;
    int   waited;

    //          req      bx       by       bd     drop  legal rsp      ex        ey       ed
    vecs[0]  = '{4'b1111, 10'd100, 10'd200, 2'b00, 1'b0, 1'b0, 4'b0001, 10'd100,  10'd200, 2'b00};
    vecs[1]  = '{4'b1111, 10'd100, 10'd200, 2'b00, 1'b0, 1'b0, 4'b0010, 10'd116,  10'd216, 2'b01};
    vecs[2]  = '{4'b1111, 10'd100, 10'd200, 2'b00, 1'b0, 1'b0, 4'b0100, 10'd132,  10'd232, 2'b10};
    vecs[3]  = '{4'b1111, 10'd100, 10'd200, 2'b00, 1'b0, 1'b0, 4'b1000, 10'd148,  10'd248, 2'b11};
    vecs[4]  = '{4'b0001, 10'd450, 10'd250, 2'b01, 1'b0, 1'b1, 4'b0001, 10'd450,  10'd250, 2'b01};
    vecs[5]  = '{4'b0101, 10'd10,  10'd20,  2'b10, 1'b0, 1'b1, 4'b0100, 10'd42,   10'd52,  2'b00};
    vecs[6]  = '{4'b0101, 10'd10,  10'd20,  2'b10, 1'b0, 1'b0, 4'b0001, 10'd10,   10'd20,  2'b10};
    vecs[7]  = '{4'b1000, 10'd975, 10'd0,   2'b11, 1'b0, 1'b1, 4'b1000, 10'd1023, 10'd48,  2'b00};
    vecs[8]  = '{4'b0110, 10'd5,   10'd7,   2'b01, 1'b0, 1'b0, 4'b0010, 10'd21,   10'd23,  2'b00};
    vecs[9]  = '{4'b0110, 10'd5,   10'd7,   2'b01, 1'b0, 1'b1, 4'b0100, 10'd37,   10'd39,  2'b11};
    vecs[10] = '{4'b0011, 10'd300, 10'd400, 2'b00, 1'b0, 1'b1, 4'b0001, 10'd300,  10'd400, 2'b00};
    vecs[11] = '{4'b0011, 10'd300, 10'd400, 2'b00, 1'b0, 1'b0, 4'b0010, 10'd316,  10'd416, 2'b01};
    vecs[12] = '{4'b0100, 10'd0,   10'd0,   2'b00, 1'b1, 1'b1, 4'b0100, 10'd32,   10'd32,  2'b10};

    rstN    = 1'b0;
    req     = '0;
    reqX    = '1;
    reqY    = '1;
    reqDir  = '1;
    mqAck   = 1'b0;
    mqLegal = 1'b0;
    #12;
    checkOutput("reset mq_valid", 32'(mqValid), 32'd0);
    checkOutput("reset rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("reset rsp_legal", 32'(rspLegal), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset mq_x", 32'(mqX), 32'd0);
    checkOutput("reset mq_y", 32'(mqY), 32'd0);
    checkOutput("reset mq_dir", 32'(mqDir), 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    for (int n = 0; n < 13; n++) begin
      applyStimulus(vecs[n], $sformatf("v%0d", n));
    end

    // Reset in WAIT: transaction is dropped, late ack ignored, priority restarts at 0.
    driveCoords(10'd600, 10'd300, 2'b00);
    req = 4'b1111;
    tick();
    tick();
    checkOutput("rstwait busy before", 32'(busy), 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rstwait busy", 32'(busy), 32'd0);
    checkOutput("rstwait mq_valid", 32'(mqValid), 32'd0);
    checkOutput("rstwait rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("rstwait mq_x", 32'(mqX), 32'd0);
    checkOutput("rstwait mq_dir", 32'(mqDir), 32'd0);
    req = '0;
    @(negedge clk);
    rstN = 1'b1;
    tick();
    mqAck   = 1'b1;
    mqLegal = 1'b1;
    tick();
    mqAck   = 1'b0;
    mqLegal = 1'b0;
    checkOutput("lateack rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("lateack busy", 32'(busy), 32'd0);
    tick();
    checkOutput("lateack rsp_valid later", 32'(rspValid), 32'd0);
    applyStimulus('{4'b1111, 10'd600, 10'd300, 2'b00, 1'b0, 1'b1, 4'b0001, 10'd600, 10'd300, 2'b00},
                  "postreset");

    // An ack during ISSUE must not complete the query.
    driveCoords(10'd0, 10'd0, 2'b11);
    req = 4'b1000;
    tick();
    mqAck   = 1'b1;
    mqLegal = 1'b1;
    tick();
    mqAck   = 1'b0;
    mqLegal = 1'b0;
    tick();
    checkOutput("issueack busy", 32'(busy), 32'd1);
    checkOutput("issueack rsp_valid", 32'(rspValid), 32'd0);
    mqAck   = 1'b1;
    mqLegal = 1'b1;
    tick();
    mqAck   = 1'b0;
    mqLegal = 1'b0;
    req     = '0;
    checkOutput("issueack resp rsp_valid", 32'(rspValid), 32'b1000);
    checkOutput("issueack resp rsp_legal", 32'(rspLegal), 32'd1);
    tick();

    // Checker never answers.
    driveCoords(10'd50, 10'd60, 2'b00);
    req = 4'b0001;
    tick();
    tick();
    req = '0;
`ifdef MAZE_QUERY_TIMEOUT_EN
    waited = 0;
    while (rspValid == '0 && waited < 40) begin
      tick();
      waited++;
    end
    checkOutput("timeout cycles", 32'(waited), 32'(TMO));
    checkOutput("timeout rsp_valid", 32'(rspValid), 32'b0001);
    checkOutput("timeout rsp_legal", 32'(rspLegal), 32'd0);
    tick();
    checkOutput("timeout idle busy", 32'(busy), 32'd0);
`else
    stuckOk = 1'b1;
    waited  = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      waited++;
      if (busy !== 1'b1 || rspValid !== '0) stuckOk = 1'b0;
    end
    checkOutput("noack busy held 100 cycles", 32'(stuckOk), 32'd1);
    mqAck   = 1'b1;
    mqLegal = 1'b1;
    tick();
    mqAck   = 1'b0;
    mqLegal = 1'b0;
    checkOutput("noack late rsp_valid", 32'(rspValid), 32'b0001);
    checkOutput("noack late rsp_legal", 32'(rspLegal), 32'd1);
    tick();
    checkOutput("noack idle busy", 32'(busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
